decay_bus_gen: RTL and testbench
================================

# decay_bus_gen

Generates the 8-line decay clock bus `dBus` consumed by every NEURON in the BRAIN array. A prescaler divides `clk` into base ticks. An 8-bit phase counter then produces eight one-cycle pulse lines with binary-spaced periods, so each neuron's `tSel` picks its decay rate. The block sits upstream of the neuron array and is frozen while the configuration bitstream is shifting.

## Interface
Parameters:
- `PRESCALE`, default 24'd10_000: `clk` cycles per base tick. Legal range is 1 to 2^24-1; 0 is an elaboration error.

Ports:
- `clk`  in  1: single clock.
- `nn_reset`  in  1: reset, asynchronous, active-high.
- `conf_en`  in  1: configuration phase. High freezes the counters and forces the bus low.
- `resync`  in  1: synchronous one-cycle phase restart.
- `dBus`  out  8: decay pulse lines. Line i is a one-cycle pulse every 2^(i+1) base ticks.
- `base_tick`  out  1: one-cycle pulse on every base tick.
- `force_decay`  in  1: present only with `DECAY_FORCE_EN`.

## Operation
- The block has three state elements:
  - `pre_cnt`: 24-bit prescaler.
  - `ph`: 8-bit phase counter.
  - Registered outputs `dBus` and `base_tick`.
- When `nn_reset` is high, all state and all outputs clear to 0 immediately.
- Each rising edge evaluates the following rules in priority order:
  1. If `resync` is high: `pre_cnt` <= 0, `ph` <= 0, `dBus` <= 0, `base_tick` <= 0. This overrides `conf_en` and any coincident tick.
  2. Otherwise, if `conf_en` is high: `pre_cnt` and `ph` hold, and both outputs go to 0.
  3. Otherwise, if `pre_cnt` == `PRESCALE`-1 (a tick edge):
     - `pre_cnt` <= 0.
     - `ph` <= `ph`+1, wrapping from 255 to 0.
     - `base_tick` <= 1.
     - For each i, `dBus[i]` <= 1 iff bits [i:0] of the new `ph` are all zero.
  4. Otherwise: `pre_cnt` <= `pre_cnt`+1, and both outputs go to 0.
- On the wrap from 255 to 0, all eight lines pulse together.
- With `PRESCALE` = 1, every edge is a tick edge, so `base_tick` is high continuously.
- When `conf_en` drops, counting resumes from the held values. No tick is lost or duplicated.

## Timing
- Reset value of every output is 0.
- All outputs are registered and change only on the rising edge of `clk`. This keeps them stable across the falling edge, where the neurons sample `dBus`.
- Edge numbering starts at edge 1, the first rising edge after `nn_reset` (or `resync`) deasserts.
- `base_tick` first asserts after edge `PRESCALE`, then every `PRESCALE` edges.
- Line i first asserts after edge 2^(i+1)·`PRESCALE`, then every 2^(i+1)·`PRESCALE` edges.
- Every pulse lasts exactly one cycle.
- Freezing: a `conf_en` high of N cycles delays all subsequent pulses by exactly N cycles.
- Asserting `nn_reset` mid-pulse clears the bus that same instant, without waiting for an edge.

## Configuration
Macro: `DECAY_FORCE_EN`.
- **Defined:**
  - The `force_decay` port exists.
  - When `force_decay` is high and `conf_en` is low, the next edge registers `dBus` = 8'hFF.
  - `pre_cnt`, `ph` and `base_tick` continue their normal behaviour.
  - `resync` and `conf_en` still take priority over the force.
- **Undefined:** the port is absent and the bus is driven only by the phase counter.

## Structure
- Shared package `neuro_pkg` holds:
  - `DBUS_W` = 8.
  - `PRESCALE_W` = 24.
  - Typedef `dbus_t` (`logic [DBUS_W-1:0]`), reused by the BRAIN and the NEURON.
- Sub-module `decay_prescaler` contains:
  - `pre_cnt`, plus its clear (driven by `resync`) and hold (driven by `conf_en`) inputs.
  - A single-cycle `tick` output that is combinational from the terminal count.
- The top level contains the phase counter, the line decode and the output registers.

## Test plan
All scenarios use `PRESCALE` = 4.
- **Reset:** hold `nn_reset` high, then release with `conf_en` = 0 → `base_tick` after edges 4, 8, 12…; `dBus` = 8'h01 after edge 8, 8'h03 after edge 16, 8'h07 after edge 32. Otherwise 0.
- **Wrap:** run 1024 edges → `dBus` = 8'hFF exactly once, after edge 1024; 128 pulses on line 0.
- **Freeze:** after edge 6, hold `conf_en` high for 10 cycles → `dBus` and `base_tick` stay 0 throughout; the next `base_tick` arrives after edge 18 instead of edge 8.
- **Resync:** assert `resync` coincident with a tick edge, with `conf_en` also high → no pulse, `ph` = 0; the next `base_tick` comes 4 edges after `resync` drops.
- **Async reset:** assert `nn_reset` mid-cycle while `dBus` = 8'h01 → `dBus` goes to 0 before the next edge.
- **Force (`DECAY_FORCE_EN`):** `force_decay` = 1 for 3 cycles → `dBus` = 8'hFF for 3 cycles; `base_tick` cadence is unchanged.

Source files
------------

// File: rtl/neuro_pkg.sv
// Shared widths and types for the neuron array: decay bus width, prescaler
// width, the decay bus type, and a helper that builds low-bit masks.
package neuro_pkg;

    localparam int DBUS_W     = 8;
    localparam int PRESCALE_W = 24;

    typedef logic [DBUS_W-1:0] dbus_t;

    // Mask with bits [i:0] set; used to test "low i+1 bits of phase are zero".
    function automatic dbus_t low_mask(input int i);
        dbus_t m;
        m = '0;
        for (int k = 0; k < DBUS_W; k++) begin
            if (k <= i) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/decay_prescaler.sv
// Base-tick prescaler for the decay bus generator. Counts clk cycles from 0
// to PRESCALE-1; tick is combinational from the terminal count so the parent
// can qualify it with its own priority rules in the same cycle.
module decay_prescaler
    import neuro_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] PRESCALE = 24'd10_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    if (PRESCALE == '0) begin : g_bad_prescale
        $error("decay_prescaler: PRESCALE must be at least 1");
    end

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;

    assign tick = (pre_cnt_q == PRESCALE - 1'b1);

    // Next count: clear beats hold, hold beats wrap, otherwise increment.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (hold) begin
            pre_cnt_d = pre_cnt_q;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // Prescaler register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/decay_bus_gen.sv
// Decay clock bus generator. A prescaler produces base ticks; an 8-bit phase
// counter advanced on each tick drives eight one-cycle pulse lines, line i
// firing every 2^(i+1) ticks. Outputs are registered so they are stable at
// the falling edge where neurons sample them.
// Optional feature macro: DECAY_FORCE_EN adds force_decay, which forces the
// whole bus high on the next edge unless resync or conf_en is asserted.
module decay_bus_gen
    import neuro_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] PRESCALE = 24'd10_000
) (
    input  logic  clk,
    input  logic  nn_reset,
    input  logic  conf_en,
    input  logic  resync,
`ifdef DECAY_FORCE_EN
    input  logic  force_decay,
`endif
    output dbus_t dBus,
    output logic  base_tick
);

    logic  tick;
    dbus_t ph_q;
    dbus_t ph_d;
    dbus_t ph_inc;
    dbus_t dbus_q;
    dbus_t dbus_d;
    logic  base_tick_q;
    logic  base_tick_d;

    decay_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (nn_reset),
        .clr  (resync),
        .hold (conf_en),
        .tick (tick)
    );

    assign ph_inc = ph_q + 1'b1;

    // Phase advance and line decode; resync outranks conf_en, which outranks a tick.
    always_comb begin
        ph_d        = ph_q;
        dbus_d      = '0;
        base_tick_d = 1'b0;
        if (resync) begin
            ph_d = '0;
        end else if (!conf_en && tick) begin
            ph_d        = ph_inc;
            base_tick_d = 1'b1;
            for (int i = 0; i < DBUS_W; i++) begin
                dbus_d[i] = ((ph_inc & low_mask(i)) == '0);
            end
        end
`ifdef DECAY_FORCE_EN
        if (!resync && !conf_en && force_decay) begin
            dbus_d = '1;
        end
`endif
    end

    // Phase counter and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge nn_reset) begin
        if (nn_reset) begin
            ph_q        <= '0;
            dbus_q      <= '0;
            base_tick_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            dbus_q      <= dbus_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign dBus      = dbus_q;
    assign base_tick = base_tick_q;

endmodule

// File: tb/tb_decay_bus_gen.sv
// Scoreboard bench for decay_bus_gen with PRESCALE = 4. Stimulus pushes the
// expected (cycle, dBus, base_tick) of every nonzero output; a negedge monitor
// pops and compares whenever the DUT presents a nonzero output.
module tb_decay_bus_gen;
    import neuro_pkg::*;

    logic  clk = 1'b0;
    logic  nn_reset = 1'b1;
    logic  conf_en = 1'b0;
    logic  resync = 1'b0;
`ifdef DECAY_FORCE_EN
    logic  force_decay = 1'b0;
`endif
    dbus_t dBus;
    logic  base_tick;

    decay_bus_gen #(
        .PRESCALE (24'd4)
    ) dut (
        .clk         (clk),
        .nn_reset    (nn_reset),
        .conf_en     (conf_en),
        .resync      (resync),
`ifdef DECAY_FORCE_EN
        .force_decay (force_decay),
`endif
        .dBus        (dBus),
        .base_tick   (base_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   dbus;
        int   bt;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  c0 = 0;
    int  tests = 0;
    int  fails = 0;
    int  l0_cnt = 0;
    int  ff_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input int d, input int b);
        ev_t e;
        e.cyc = c; e.dbus = d; e.bt = b;
        q.push_back(e);
    endfunction

    // Expected bus after base tick number t: line i fires when t is a multiple of 2^(i+1).
    function automatic int exp_dbus(input int t);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((t % (2 << i)) == 0) r = r | (1 << i);
        end
        return r;
    endfunction

    // Monitor: every nonzero output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!nn_reset && (dBus != '0 || base_tick)) begin
            if (dBus[0]) l0_cnt++;
            if (dBus == 8'hFF) ff_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_output", {23'd0, base_tick, dBus}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_cycle", cyc - c0, e.cyc - c0);
                chk("event_dbus", int'(dBus), e.dbus);
                chk("event_tick", int'(base_tick), e.bt);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        nn_reset = 1'b1;
        conf_en  = 1'b0;
        resync   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dbus", int'(dBus), 0);
        chk("reset_tick", int'(base_tick), 0);
        nn_reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic end_scenario(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        // Reset release and full phase wrap: 256 ticks in 1024 edges.
        do_reset();
        l0_cnt = 0;
        ff_cnt = 0;
        push(c0 + 4,  32'h00, 1);
        push(c0 + 8,  32'h01, 1);
        push(c0 + 12, 32'h00, 1);
        push(c0 + 16, 32'h03, 1);
        push(c0 + 20, 32'h00, 1);
        push(c0 + 24, 32'h01, 1);
        push(c0 + 28, 32'h00, 1);
        push(c0 + 32, 32'h07, 1);
        for (int t = 9; t <= 256; t++) push(c0 + 4 * t, exp_dbus(t), 1);
        wait_to(c0 + 1027);
        end_scenario("wrap_pending");
        chk("wrap_line0_pulses", l0_cnt, 128);
        chk("wrap_ff_count", ff_cnt, 1);

        // Freeze: conf_en high for 10 cycles after edge 6 shifts tick 2 to edge 18.
        do_reset();
        push(c0 + 4,  32'h00, 1);
        push(c0 + 18, 32'h01, 1);
        push(c0 + 22, 32'h00, 1);
        wait_to(c0 + 6);
        conf_en = 1'b1;
        repeat (10) @(negedge clk);
        conf_en = 1'b0;
        wait_to(c0 + 23);
        end_scenario("freeze_pending");

        // Resync with conf_en on the tick edge 8: no pulse, phase restarts.
        do_reset();
        push(c0 + 4,  32'h00, 1);
        push(c0 + 12, 32'h00, 1);
        push(c0 + 16, 32'h01, 1);
        wait_to(c0 + 7);
        resync  = 1'b1;
        conf_en = 1'b1;
        @(negedge clk);
        resync  = 1'b0;
        conf_en = 1'b0;
        wait_to(c0 + 17);
        end_scenario("resync_pending");

        // Asynchronous reset in the middle of the dBus = 8'h01 pulse.
        do_reset();
        push(c0 + 4, 32'h00, 1);
        push(c0 + 8, 32'h01, 1);
        wait_to(c0 + 8);
        #2;
        chk("async_pre_dbus", int'(dBus), 32'h01);
        nn_reset = 1'b1;
        #1;
        chk("async_post_dbus", int'(dBus), 0);
        chk("async_post_tick", int'(base_tick), 0);
        end_scenario("async_pending");

`ifdef DECAY_FORCE_EN
        // Force for edges 2..4; base tick cadence unchanged.
        do_reset();
        push(c0 + 2, 32'hFF, 0);
        push(c0 + 3, 32'hFF, 0);
        push(c0 + 4, 32'hFF, 1);
        push(c0 + 8, 32'h01, 1);
        wait_to(c0 + 1);
        force_decay = 1'b1;
        repeat (3) @(negedge clk);
        force_decay = 1'b0;
        wait_to(c0 + 9);
        end_scenario("force_pending");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
